// File: rtl/cp0_ctrl.sv
// cp0_ctrl -- MIPS32 coprocessor-0 register block.
//
// Holds Count, Compare, Status, Cause, EPC, BadVAddr, PRId and Config.
// mtc0 writes arrive from writeback, mfc0 reads from execute, and exception
// / eret commits from the memory stage.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   we_i, waddr_i, data_i    mtc0 write
//   raddr_i, data_o          mfc0 read (combinational, no write bypass)
//   int_i                    external interrupt levels -> Cause.IP[2+i]
//   exc_*_i                  exception commit (code, pc, delay slot, bad addr)
//   eret_i                   eret commit (clears Status.EXL)
//   count_o .. badvaddr_o    register contents
//   timer_int_o              sticky timer interrupt
//   int_pending_o            unmasked interrupt pending
module cp0_ctrl #(
  parameter int          HW_INT_NUM   = 6,
  parameter int          COUNT_DIV    = 2,
  parameter int          TIMER_IP     = 7,
  parameter logic [31:0] PRID_VALUE   = 32'h004C0102,
  parameter logic [31:0] CONFIG_VALUE = 32'h00008000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [4:0]            waddr_i,
  input  logic [4:0]            raddr_i,
  input  logic [31:0]           data_i,
  input  logic [HW_INT_NUM-1:0] int_i,
  input  logic                  exc_valid_i,
  input  logic [4:0]            exc_code_i,
  input  logic [31:0]           exc_pc_i,
  input  logic                  exc_bd_i,
  input  logic [31:0]           exc_badvaddr_i,
  input  logic                  eret_i,
  output logic [31:0]           data_o,
  output logic [31:0]           count_o,
  output logic [31:0]           compare_o,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o,
  output logic [31:0]           epc_o,
  output logic [31:0]           badvaddr_o,
  output logic                  timer_int_o,
  output logic                  int_pending_o
);

  localparam logic [4:0] ADDR_BADVADDR = 5'd8;
  localparam logic [4:0] ADDR_COUNT    = 5'd9;
  localparam logic [4:0] ADDR_COMPARE  = 5'd11;
  localparam logic [4:0] ADDR_STATUS   = 5'd12;
  localparam logic [4:0] ADDR_CAUSE    = 5'd13;
  localparam logic [4:0] ADDR_EPC      = 5'd14;
  localparam logic [4:0] ADDR_PRID     = 5'd15;
  localparam logic [4:0] ADDR_CONFIG   = 5'd16;

  localparam logic [3:0] DIV_LAST = 4'(COUNT_DIV - 1);

  logic [31:0]           count_q, count_d;
  logic [31:0]           compare_q, compare_d;
  logic [3:0]            div_cnt_q, div_cnt_d;
  logic                  timer_q, timer_d;
  logic [3:0]            cu_q, cu_d;
  logic                  bev_q, bev_d;
  logic [7:0]            im_q, im_d;
  logic                  exl_q, exl_d;
  logic                  ie_q, ie_d;
  logic                  bd_q, bd_d;
  logic [4:0]            exc_code_q, exc_code_d;
  logic                  iv_q, iv_d;
  logic                  wp_q, wp_d;
  logic [1:0]            ip_sw_q, ip_sw_d;
  logic [HW_INT_NUM-1:0] ip_hw_q, ip_hw_d;
  logic [31:0]           epc_q, epc_d;
  logic [31:0]           badvaddr_q, badvaddr_d;

  logic       wr_count, wr_compare, wr_status, wr_cause, wr_epc;
  logic       eret_take;
  logic [7:0] ip;
  logic [31:0] status_w, cause_w;

  assign wr_count   = we_i && (waddr_i == ADDR_COUNT);
  assign wr_compare = we_i && (waddr_i == ADDR_COMPARE);
  assign wr_status  = we_i && (waddr_i == ADDR_STATUS);
  assign wr_cause   = we_i && (waddr_i == ADDR_CAUSE);
  assign wr_epc     = we_i && (waddr_i == ADDR_EPC);
  // An exception in the same cycle swallows the eret.
  assign eret_take  = eret_i && !exc_valid_i;

  always_comb begin
    ip = '0;
    ip[1:0] = ip_sw_q;
    for (int i = 0; i < HW_INT_NUM; i++) ip[2+i] = ip_hw_q[i];
    ip[TIMER_IP] = ip[TIMER_IP] | timer_q;
  end

  assign status_w = {cu_q, 5'b0, bev_q, 6'b0, im_q, 6'b0, exl_q, ie_q};
  assign cause_w  = {bd_q, timer_q, 6'b0, iv_q, wp_q, 6'b0, ip, 1'b0, exc_code_q, 2'b0};

  always_comb begin
    count_d    = count_q;
    div_cnt_d  = div_cnt_q;
    compare_d  = compare_q;
    timer_d    = timer_q;
    cu_d       = cu_q;
    bev_d      = bev_q;
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    iv_d       = iv_q;
    wp_d       = wp_q;
    ip_sw_d    = ip_sw_q;
    ip_hw_d    = int_i;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;

    // Count: a software load restarts the prescaler and beats the tick.
    if (wr_count) begin
      count_d   = data_i;
      div_cnt_d = '0;
    end else if (div_cnt_q == DIV_LAST) begin
      count_d   = count_q + 32'd1;
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + 4'd1;
    end

    // Timer: set on match, cleared by a Compare write (clear wins a tie).
    if ((compare_q != 32'd0) && (count_q == compare_q)) timer_d = 1'b1;
    if (wr_compare) begin
      compare_d = data_i;
      timer_d   = 1'b0;
    end

    // mtc0 first; exception/eret below override the fields they own.
    if (wr_status) begin
      cu_d  = data_i[31:28];
      bev_d = data_i[22];
      im_d  = data_i[15:8];
      exl_d = data_i[1];
      ie_d  = data_i[0];
    end
    if (wr_cause) begin
      iv_d    = data_i[23];
      wp_d    = data_i[22];
      ip_sw_d = data_i[9:8];
    end
    if (wr_epc) epc_d = data_i;

    if (exc_valid_i) begin
      // Nested exceptions keep the original return point; EPC is not
      // open to a same-cycle mtc0 either way.
      epc_d = epc_q;
      if (!exl_q) begin
        epc_d = exc_bd_i ? (exc_pc_i - 32'd4) : exc_pc_i;
        bd_d  = exc_bd_i;
      end
      exl_d      = 1'b1;
      exc_code_d = exc_code_i;
      if ((exc_code_i == 5'd4) || (exc_code_i == 5'd5)) badvaddr_d = exc_badvaddr_i;
    end else if (eret_take) begin
      exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q    <= '0;
      div_cnt_q  <= '0;
      compare_q  <= '0;
      timer_q    <= 1'b0;
      cu_q       <= 4'b0001;
      bev_q      <= 1'b0;
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      exc_code_q <= '0;
      iv_q       <= 1'b0;
      wp_q       <= 1'b0;
      ip_sw_q    <= '0;
      ip_hw_q    <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
    end else begin
      count_q    <= count_d;
      div_cnt_q  <= div_cnt_d;
      compare_q  <= compare_d;
      timer_q    <= timer_d;
      cu_q       <= cu_d;
      bev_q      <= bev_d;
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      exc_code_q <= exc_code_d;
      iv_q       <= iv_d;
      wp_q       <= wp_d;
      ip_sw_q    <= ip_sw_d;
      ip_hw_q    <= ip_hw_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
    end
  end

  // Read path; gated by reset so the constant registers also read 0 then.
  always_comb begin
    data_o = '0;
    if (rst) begin
      case (raddr_i)
        ADDR_BADVADDR: data_o = badvaddr_q;
        ADDR_COUNT:    data_o = count_q;
        ADDR_COMPARE:  data_o = compare_q;
        ADDR_STATUS:   data_o = status_w;
        ADDR_CAUSE:    data_o = cause_w;
        ADDR_EPC:      data_o = epc_q;
        ADDR_PRID:     data_o = PRID_VALUE;
        ADDR_CONFIG:   data_o = CONFIG_VALUE;
        default:       data_o = '0;
      endcase
    end
  end

  assign count_o       = count_q;
  assign compare_o     = compare_q;
  assign status_o      = status_w;
  assign cause_o       = cause_w;
  assign epc_o         = epc_q;
  assign badvaddr_o    = badvaddr_q;
  assign timer_int_o   = timer_q;
  assign int_pending_o = ie_q & ~exl_q & (|(ip & im_q));

endmodule

// File: tb/tb_cp0_ctrl.sv
module tb_cp0_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i, raddr_i;
  logic [31:0] data_i;
  logic [5:0]  int_i;
  logic        exc_valid_i;
  logic [4:0]  exc_code_i;
  logic [31:0] exc_pc_i;
  logic        exc_bd_i;
  logic [31:0] exc_badvaddr_i;
  logic        eret_i;
  logic [31:0] data_o, count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o;
  logic        timer_int_o, int_pending_o;

  cp0_ctrl dut (
    .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .raddr_i(raddr_i),
    .data_i(data_i), .int_i(int_i), .exc_valid_i(exc_valid_i),
    .exc_code_i(exc_code_i), .exc_pc_i(exc_pc_i), .exc_bd_i(exc_bd_i),
    .exc_badvaddr_i(exc_badvaddr_i), .eret_i(eret_i), .data_o(data_o),
    .count_o(count_o), .compare_o(compare_o), .status_o(status_o),
    .cause_o(cause_o), .epc_o(epc_o), .badvaddr_o(badvaddr_o),
    .timer_int_o(timer_int_o), .int_pending_o(int_pending_o)
  );

  always #50 clk = ~clk;

  localparam int K_DATA = 0, K_COUNT = 1, K_COMPARE = 2, K_STATUS = 3,
                 K_CAUSE = 4, K_EPC = 5, K_BADV = 6, K_TIMER = 7, K_PEND = 8;

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  function automatic logic [31:0] observe(int kind);
    case (kind)
      K_DATA:    return data_o;
      K_COUNT:   return count_o;
      K_COMPARE: return compare_o;
      K_STATUS:  return status_o;
      K_CAUSE:   return cause_o;
      K_EPC:     return epc_o;
      K_BADV:    return badvaddr_o;
      K_TIMER:   return {31'b0, timer_int_o};
      default:   return {31'b0, int_pending_o};
    endcase
  endfunction

  task automatic push_exp(string tag, int kind, logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.kind = kind; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = observe(e.kind);
      checks++;
      assert (obs === e.exp)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic read_chk(string tag, logic [4:0] addr, logic [31:0] exp);
    raddr_i = addr;
    #1;
    push_exp(tag, K_DATA, exp);
    drain();
  endtask

  task automatic mtc0(logic [4:0] addr, logic [31:0] d);
    we_i = 1'b1; waddr_i = addr; data_i = d;
  endtask

  initial begin
    bit found;
    rst = 1'b0; we_i = 0; waddr_i = 0; raddr_i = 5'd15; data_i = 0; int_i = 0;
    exc_valid_i = 0; exc_code_i = 0; exc_pc_i = 0; exc_bd_i = 0;
    exc_badvaddr_i = 0; eret_i = 0;

    step(2);
    push_exp("rst_data_zero", K_DATA, 32'h0);
    push_exp("rst_status", K_STATUS, 32'h10000000);
    drain();

    rst = 1'b1;
    read_chk("rd_badvaddr", 5'd8, 32'h0);
    read_chk("rd_count", 5'd9, 32'h0);
    read_chk("rd_compare", 5'd11, 32'h0);
    read_chk("rd_status", 5'd12, 32'h10000000);
    read_chk("rd_cause", 5'd13, 32'h0);
    read_chk("rd_epc", 5'd14, 32'h0);
    read_chk("rd_prid", 5'd15, 32'h004C0102);
    read_chk("rd_config", 5'd16, 32'h00008000);
    read_chk("rd_unmapped3", 5'd3, 32'h0);

    // Prescaler: two clocks per Count tick.
    step(10);
    push_exp("count_after10", K_COUNT, 32'd5);
    drain();

    mtc0(5'd9, 32'hFFFFFFFF);
    step(1);
    we_i = 0;
    push_exp("count_load", K_COUNT, 32'hFFFFFFFF);
    drain();
    step(2);
    push_exp("count_wrap", K_COUNT, 32'h0);
    drain();

    // Timer
    mtc0(5'd11, 32'd4);
    step(1);
    we_i = 0;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      if (count_o == 32'd4) begin
        found = 1;
        break;
      end
      step(1);
    end
    checks++;
    assert (found)
    else begin
      failures++;
      $error("FAIL count_reach4 observed=%h expected=%h", count_o, 32'd4);
    end
    push_exp("timer_not_yet", K_TIMER, 32'd0);
    drain();
    step(1);
    push_exp("timer_set", K_TIMER, 32'd1);
    push_exp("cause_ti_ip7", K_CAUSE, 32'h40008000);
    drain();
    // Compare write lands in a cycle where count still matches: clear wins.
    mtc0(5'd11, 32'd100);
    step(1);
    we_i = 0;
    push_exp("timer_clear", K_TIMER, 32'd0);
    push_exp("compare_100", K_COMPARE, 32'd100);
    push_exp("count_5", K_COUNT, 32'd5);
    drain();

    // Interrupt pending and first exception
    mtc0(5'd12, 32'h0000FF01);
    int_i = 6'b000001;
    step(1);
    we_i = 0;
    push_exp("status_ff01", K_STATUS, 32'h0000FF01);
    push_exp("pend_hw0", K_PEND, 32'd1);
    push_exp("cause_ip2", K_CAUSE, 32'h00000400);
    drain();
    read_chk("rd_status_ff01", 5'd12, 32'h0000FF01);

    exc_valid_i = 1; exc_code_i = 5'd0; exc_pc_i = 32'h1000; exc_bd_i = 1;
    step(1);
    exc_valid_i = 0; exc_bd_i = 0;
    push_exp("epc_bd", K_EPC, 32'h00000FFC);
    push_exp("cause_bd", K_CAUSE, 32'h80000400);
    push_exp("status_exl", K_STATUS, 32'h0000FF03);
    push_exp("pend_masked_exl", K_PEND, 32'd0);
    drain();

    // Nested exception with EXL=1
    exc_valid_i = 1; exc_code_i = 5'd5; exc_pc_i = 32'h2000; exc_badvaddr_i = 32'h3;
    step(1);
    exc_valid_i = 0;
    push_exp("epc_hold", K_EPC, 32'h00000FFC);
    push_exp("cause_code5", K_CAUSE, 32'h80000414);
    push_exp("badvaddr_cap", K_BADV, 32'h3);
    drain();
    read_chk("rd_badvaddr_3", 5'd8, 32'h3);

    eret_i = 1;
    step(1);
    eret_i = 0;
    push_exp("eret_exl0", K_STATUS, 32'h0000FF01);
    push_exp("pend_after_eret", K_PEND, 32'd1);
    drain();

    // Cause write mask; BD and ExcCode retained from the prior exceptions.
    mtc0(5'd13, 32'hFFFFFFFF);
    int_i = 6'b0;
    step(1);
    we_i = 0;
    push_exp("cause_wmask", K_CAUSE, 32'h80C00314);
    push_exp("pend_sw", K_PEND, 32'd1);
    drain();

    mtc0(5'd8, 32'hDEADBEEF);
    step(1);
    we_i = 0;
    push_exp("badvaddr_ro", K_BADV, 32'h3);
    drain();

    // exc + eret + mtc0 Status together
    exc_valid_i = 1; eret_i = 1; exc_code_i = 5'd12; exc_pc_i = 32'h3000; exc_bd_i = 0;
    mtc0(5'd12, 32'h2040FF00);
    step(1);
    exc_valid_i = 0; eret_i = 0; we_i = 0;
    push_exp("status_exc_eret", K_STATUS, 32'h2040FF02);
    push_exp("epc_3000", K_EPC, 32'h3000);
    push_exp("cause_code12", K_CAUSE, 32'h00C00330);
    push_exp("pend_exl", K_PEND, 32'd0);
    drain();

    // Asynchronous reset mid-cycle
    step(3);
    #20;
    rst = 1'b0;
    raddr_i = 5'd15;
    #1;
    push_exp("arst_count", K_COUNT, 32'h0);
    push_exp("arst_compare", K_COMPARE, 32'h0);
    push_exp("arst_status", K_STATUS, 32'h10000000);
    push_exp("arst_cause", K_CAUSE, 32'h0);
    push_exp("arst_epc", K_EPC, 32'h0);
    push_exp("arst_badvaddr", K_BADV, 32'h0);
    push_exp("arst_timer", K_TIMER, 32'd0);
    push_exp("arst_data", K_DATA, 32'h0);
    drain();
    step(1);
    rst = 1'b1;
    step(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cp0_ctrl.md
Name: cp0_ctrl

Overview:
Parametrised coprocessor-0 register block for the MIPS32 pipeline. It holds Count, Compare, Status, Cause, EPC, BadVAddr, PRId and Config. It receives mtc0 writes from the writeback stage and mfc0 reads from the execute stage. It also takes exception and eret commits from the memory stage. Beyond the previous CP0 it adds a configurable external interrupt width, a Count prescaler, BadVAddr capture, write masking on Status/Cause, and a combinational interrupt-pending output for the exception logic.

Parameters:
HW_INT_NUM, 6, number of external interrupt lines, 1..6; mapped to Cause.IP[2+i].
COUNT_DIV, 2, clock cycles per Count increment, 1..16.
TIMER_IP, 7, Cause.IP bit (2..7) that the timer interrupt ORs into.
PRID_VALUE, 32'h004C0102, constant PRId contents.
CONFIG_VALUE, 32'h00008000, constant Config contents (BE=1).

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
we_i  in  1  mtc0 write enable
waddr_i  in  5  mtc0 register address
raddr_i  in  5  mfc0 register address
data_i  in  32  mtc0 write data
int_i  in  HW_INT_NUM  external interrupt levels
exc_valid_i  in  1  exception commit this cycle
exc_code_i  in  5  ExcCode of the committed exception
exc_pc_i  in  32  PC of the faulting instruction
exc_bd_i  in  1  faulting instruction is in a delay slot
exc_badvaddr_i  in  32  faulting address (AdEL/AdES only)
eret_i  in  1  eret commit this cycle
data_o  out  32  mfc0 read data
count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o  out  32 each  register contents
timer_int_o  out  1  timer interrupt, sticky
int_pending_o  out  1  unmasked interrupt pending

Behaviour:
- Addresses:
  - BadVAddr=8, Count=9, Compare=11, Status=12, Cause=13, EPC=14, PRId=15, Config=16.
- Reset (rst=0, asynchronous), all cleared except:
  - status_o=32'h10000000 (CU0=1).
  - Prescaler counter cleared.
  - timer_int_o=0.
  - PRId and Config are constants and are not reset-dependent.
- Count prescaler:
  - Internal counter div_cnt runs 0..COUNT_DIV-1.
  - count_o increments, wrapping at 2^32, on the cycle div_cnt==COUNT_DIV-1.
  - With COUNT_DIV=1, count_o increments every cycle.
  - An mtc0 to Count loads data_i, resets div_cnt to 0, and overrides that cycle's increment.
- Timer:
  - When compare_o!=0 and count_o==compare_o, timer_int_o is set next cycle.
  - timer_int_o stays set until an mtc0 to Compare clears it.
  - If the Compare write and the match occur in the same cycle, the clear wins.
- Cause:
  - IP[2+i] is registered from int_i[i] every cycle; IP bits above HW_INT_NUM+1 are 0.
  - IP[TIMER_IP] is ORed with timer_int_o.
  - Cause[30] (TI) equals timer_int_o.
  - mtc0 writes only IP[1:0], IV[23] and WP[22]; other bits are unchanged.
- Status:
  - mtc0 writes bits {CU[31:28], BEV[22], IM[15:8], EXL[1], IE[0]}.
  - All other bits read 0.
- EPC: fully writable.
- BadVAddr, PRId, Config: read-only; writes are ignored.
- Exception commit (exc_valid_i=1):
  - If Status.EXL==0: epc_o = exc_bd_i ? exc_pc_i-4 : exc_pc_i, and Cause.BD = exc_bd_i.
  - If Status.EXL==1: EPC and BD hold.
  - EXL is set to 1 in both cases.
  - Cause.ExcCode[6:2] = exc_code_i.
  - If exc_code_i is 4 or 5, badvaddr_o = exc_badvaddr_i.
- eret_i: clears Status.EXL.
- Same-cycle priority, highest first:
  - exc_valid_i over eret_i; eret_i is ignored when both are asserted.
  - Exception or eret over an mtc0 to the same field.
  - An mtc0 to other fields still takes effect.
- int_pending_o = Status.IE & ~Status.EXL & |(Cause.IP[7:0] & Status.IM[7:0]). It is combinational from registers.
- Read path:
  - data_o is combinational from raddr_i and returns current register contents, with no bypass of a same-cycle write.
  - Unmapped addresses return 0.
  - During reset data_o is 0.

Test Plan:
- Reset, then read every address -> Status 0x10000000, PRId 0x004C0102, Config 0x00008000, all others 0; unmapped address 3 -> 0.
- COUNT_DIV=2, run 10 cycles after reset -> count_o=5; mtc0 Count=0xFFFFFFFF, run 2 cycles -> count_o=0, no X.
- Compare=4 with Count counting -> timer_int_o=1 one cycle after count_o==4, Cause[30]=1 and Cause.IP[7]=1; mtc0 Compare=100 -> timer_int_o=0.
- Status=0x0000FF01 with int_i=6'b000001 -> int_pending_o=1; commit exc_code=0, exc_pc=0x1000, bd=1 -> EPC=0xFFC, BD=1, EXL=1, int_pending_o=0.
- With EXL=1, commit exc_code=5, pc=0x2000, badvaddr=0x3 -> EPC unchanged, ExcCode=5, BadVAddr=0x3; then eret_i -> EXL=0.
- mtc0 Cause=0xFFFFFFFF -> only bits 23, 22, 9, 8 set; simultaneous exc_valid_i and eret_i -> EXL stays 1; assert rst mid-count -> all registers return to reset values immediately, without waiting for a clock edge.
